nand_gate_sequencer: RTL and testbench
======================================

Name: nand_gate_sequencer

Overview:
- Self-test controller for the NAND-built gate bank (AND, OR, NOR, XOR).
- On a start pulse it selects each gate in turn and applies all four input vectors. After a settle time it samples the selected gate's output and compares it against the built-in truth table.
- Reports error count, per-gate fail mask and pass/fail, with a start/busy/done handshake.
- Sits between the gate bank (driven through in1/in2/gate_sel) and any higher-level test or status logic.

Parameters:
- SETTLE_CYCLES, 2, cycles between applying a vector and sampling gate_out; legal range >= 1.
- ERR_W, 4, width of err_count; the count saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a test run; sampled only in IDLE
- abort  input  1  synchronous abort; returns to IDLE
- gate_out  input  1  output of the gate selected by gate_sel
- gate_sel  output  2  gate select: 0=AND 1=OR 2=NOR 3=XOR
- in1  output  1  gate input A
- in2  output  1  gate input B
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  one-cycle pulse at the end of a run
- pass  output  1  1 when the last completed run had zero errors
- err_count  output  ERR_W  mismatches in the last or current run, saturating
- fail_mask  output  4  bit g is set if gate g mismatched at least once

Behaviour:
- Interface decided: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: gate_sel=0, in1=0, in2=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state=IDLE. All outputs are registered.
- States are IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - in1=in2=0; pass, err_count and fail_mask hold their values.
  - On start=1: go to APPLY, set sel=0 and vec=0, clear err_count and fail_mask, clear pass, set busy=1.
- APPLY (1 cycle): drive {in1,in2}=vec, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Holds inputs and decrements the counter.
  - Moves to CHECK in the cycle after the counter reads 0.
  - The state lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - Compare gate_out with EXPECT[sel*4+vec].
  - On mismatch: err_count increments, saturating; fail_mask[sel] is set.
  - If vec=3 and sel=3, go to DONE.
  - Otherwise vec increments. When vec wraps 3->0, sel increments. Then go to APPLY.
- DONE (1 cycle):
  - done=1, busy=0, pass=(err_count==0), in1=in2=0, then go to IDLE.
  - A mismatch in the final CHECK is included in pass.
- Timing:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - done goes high 16*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start: 65 cycles at the default.
  - gate_sel stays at 3 after a run and returns to 0 on the next start.
- Truth table, indexed by vec={in1,in2} = 0,1,2,3:
  - AND: 0,0,0,1
  - OR: 0,1,1,1
  - NOR: 1,0,0,0
  - XOR: 0,1,1,0
- start while busy is ignored. start and abort together in IDLE: abort wins and start is ignored.
- abort in any non-IDLE state:
  - Next state is IDLE; busy=0; no done pulse; pass=0.
  - err_count and fail_mask hold their partial values; in1=in2=0.
- Asynchronous reset during a run returns every output to its reset value immediately; there is no done pulse.
- err_count saturation: further mismatches do not wrap; fail_mask still updates.

Decomposition:
- Shared header nand_seq_defs.vh holds:
  - gate codes GATE_AND/OR/NOR/XOR
  - 16-bit EXPECT table constant, bit index sel*4+vec
  - state encodings
- One combinational sub-module, gate_expect, maps (sel, vec) to the expected bit. It is reused by the bench scoreboard.

Test Plan:
- Ideal gate model behind gate_sel, start pulse, SETTLE_CYCLES=2 -> done at +65 cycles, pass=1, err_count=0, fail_mask=0000, busy high for 64 cycles.
- gate_out stuck at 0 -> err_count=7, fail_mask=1111, pass=0.
- gate_out stuck at 1 -> err_count=9, fail_mask=1111, pass=0.
- NOR replaced by OR, others ideal -> err_count=4, fail_mask=0100, pass=0.
- Ideal run; abort in cycle 20; start re-pulsed during busy on a second run -> the first run produces no done pulse, busy=0, pass=0, and the FSM is in IDLE the next cycle; the extra start is ignored and the second run completes normally at +65 cycles.
- rst_n pulled low mid-run -> all outputs 0 immediately; after release, a new start gives a full normal run. With ERR_W=2 and stuck-at-1 -> err_count saturates at 3.

Source files
------------

// File: rtl/nand_gate_sequencer_pkg.sv
// Shared definitions for the NAND gate-bank self-test sequencer:
// gate codes, expected truth table and controller states.
package nand_gate_sequencer_pkg;

    typedef enum logic [1:0] {
        GATE_AND = 2'd0,
        GATE_OR  = 2'd1,
        GATE_NOR = 2'd2,
        GATE_XOR = 2'd3
    } gate_e;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    // Bit index is sel*4 + vec, with vec = {in1,in2}.
    // XOR=0110, NOR=0001, OR=1110, AND=1000 (nibbles listed MSB first).
    localparam logic [15:0] EXPECT = 16'h61E8;

    function automatic logic expect_bit(input logic [1:0] sel, input logic [1:0] vec);
        return EXPECT[{sel, vec}];
    endfunction

endpackage

// File: rtl/nand_gate_sequencer_gate_expect.sv
// Combinational lookup of the expected gate output for a (gate, vector) pair.
module gate_expect
    import nand_gate_sequencer_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [1:0] vec,
    output logic       exp_bit
);

    always_comb begin
        exp_bit = expect_bit(sel, vec);
    end

endmodule

// File: rtl/nand_gate_sequencer.sv
// Self-test controller: walks every gate of the NAND-built bank through all
// four input vectors and reports mismatches against the reference truth table.
module nand_gate_sequencer
    import nand_gate_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             gate_out,
    output logic [1:0]       gate_sel,
    output logic             in1,
    output logic             in2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_mask
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e           state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] cnt;
    logic             exp_bit;

    gate_expect u_expect (
        .sel     (gate_sel),
        .vec     (vec),
        .exp_bit (exp_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            cnt       <= '0;
            gate_sel  <= GATE_AND;
            in1       <= 1'b0;
            in2       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            done <= 1'b0;
            // Abort outranks every state action, including the CHECK update.
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
                in1   <= 1'b0;
                in2   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        in1 <= 1'b0;
                        in2 <= 1'b0;
                        if (start && !abort) begin
                            state     <= APPLY;
                            gate_sel  <= GATE_AND;
                            vec       <= '0;
                            err_count <= '0;
                            fail_mask <= '0;
                            pass      <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    APPLY: begin
                        {in1, in2} <= vec;
                        cnt        <= CNT_W'(SETTLE_CYCLES - 1);
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= CHECK;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    CHECK: begin
                        if (gate_out != exp_bit) begin
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            fail_mask[gate_sel] <= 1'b1;
                        end
                        if ((vec == 2'd3) && (gate_sel == GATE_XOR)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            vec <= vec + 2'd1;
                            if (vec == 2'd3) begin
                                gate_sel <= gate_sel + 2'd1;
                            end
                            state <= APPLY;
                        end
                    end
                    DONE: begin
                        // err_count already holds the final CHECK result here.
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_count == '0);
                        in1   <= 1'b0;
                        in2   <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nand_gate_sequencer.sv
// Bench for nand_gate_sequencer: truth-table vectors plus directed full runs
// against an ideal or faulty gate bank model.
module tb_nand_gate_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters. Instance B: SETTLE_CYCLES=1, ERR_W=2.
    logic       start_a, abort_a, gate_out_a, in1_a, in2_a, busy_a, done_a, pass_a;
    logic [1:0] gate_sel_a;
    logic [3:0] err_a, mask_a;
    logic       start_b, abort_b, gate_out_b, in1_b, in2_b, busy_b, done_b, pass_b;
    logic [1:0] gate_sel_b;
    logic [1:0] err_b;
    logic [3:0] mask_b;

    // Gate-bank fault modes: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 NOR wired as OR.
    logic [1:0] mode_a, mode_b;

    nand_gate_sequencer #(.SETTLE_CYCLES(2), .ERR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .gate_out(gate_out_a),
        .gate_sel(gate_sel_a), .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .fail_mask(mask_a)
    );

    nand_gate_sequencer #(.SETTLE_CYCLES(1), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .gate_out(gate_out_b),
        .gate_sel(gate_sel_b), .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .fail_mask(mask_b)
    );

    logic [1:0] t_sel, t_vec;
    logic       t_exp;
    gate_expect u_table (.sel(t_sel), .vec(t_vec), .exp_bit(t_exp));

    function automatic logic model(input logic [1:0] m, input logic [1:0] s, input logic a, input logic b);
        logic [1:0] g;
        g = (m == 2'd3 && s == 2'd2) ? 2'd1 : s;
        if (m == 2'd1) return 1'b0;
        if (m == 2'd2) return 1'b1;
        case (g)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    always_comb gate_out_a = model(mode_a, gate_sel_a, in1_a, in2_a);
    always_comb gate_out_b = model(mode_b, gate_sel_b, in1_b, in2_b);

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [1:0] vec;
        logic       exp;
    } tt_rec_t;
    tt_rec_t tbl[16];

    // Pulses start on the chosen instance and waits for done. k=0 is the
    // first negedge after the start-sampling edge; optional extra start at k.
    task automatic run(input bit b, input int restart_at, output int dk, output int bn,
                       output logic [1:0] sel0);
        dk = -1;
        bn = 0;
        sel0 = 2'bxx;
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (b) start_b = (k == restart_at); else start_a = (k == restart_at);
            if (k == 0) sel0 = b ? gate_sel_b : gate_sel_a;
            if (b ? done_b : done_a) begin
                dk = k;
                break;
            end
            if (b ? busy_b : busy_a) bn++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        if (dk < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_run_a(input string tag, input int dk, input int bn, input logic [1:0] sel0,
                             input int exp_err, input logic [3:0] exp_mask, input logic exp_pass);
        chk({tag, "_done_cycle"}, dk, 65);
        chk({tag, "_busy_cycles"}, bn, 64);
        chk({tag, "_sel_at_start"}, sel0, 0);
        chk({tag, "_err"}, err_a, exp_err);
        chk({tag, "_mask"}, mask_a, exp_mask);
        chk({tag, "_pass"}, pass_a, exp_pass);
        chk({tag, "_sel_after"}, gate_sel_a, 3);
        chk({tag, "_inputs_idle"}, {in1_a, in2_a}, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_a, 0);
    endtask

    int dk, bn;
    logic [1:0] s0;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        mode_a = 2'd0; mode_b = 2'd0;
        t_sel = '0; t_vec = '0;

        tbl[0]  = '{2'd0, 2'd0, 1'b0}; tbl[1]  = '{2'd0, 2'd1, 1'b0};
        tbl[2]  = '{2'd0, 2'd2, 1'b0}; tbl[3]  = '{2'd0, 2'd3, 1'b1};
        tbl[4]  = '{2'd1, 2'd0, 1'b0}; tbl[5]  = '{2'd1, 2'd1, 1'b1};
        tbl[6]  = '{2'd1, 2'd2, 1'b1}; tbl[7]  = '{2'd1, 2'd3, 1'b1};
        tbl[8]  = '{2'd2, 2'd0, 1'b1}; tbl[9]  = '{2'd2, 2'd1, 1'b0};
        tbl[10] = '{2'd2, 2'd2, 1'b0}; tbl[11] = '{2'd2, 2'd3, 1'b0};
        tbl[12] = '{2'd3, 2'd0, 1'b0}; tbl[13] = '{2'd3, 2'd1, 1'b1};
        tbl[14] = '{2'd3, 2'd2, 1'b1}; tbl[15] = '{2'd3, 2'd3, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {gate_sel_a, in1_a, in2_a, busy_a, done_a, pass_a, err_a, mask_a}, 0);
        chk("reset_outputs_b", {gate_sel_b, in1_b, in2_b, busy_b, done_b, pass_b, err_b, mask_b}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            t_sel = tbl[i].sel;
            t_vec = tbl[i].vec;
            #1;
            chk($sformatf("truth_table_%0d", i), t_exp, tbl[i].exp);
        end

        mode_a = 2'd0;
        run(1'b0, -1, dk, bn, s0);
        chk_run_a("ideal", dk, bn, s0, 0, 4'b0000, 1'b1);

        mode_a = 2'd1;
        run(1'b0, -1, dk, bn, s0);
        chk_run_a("stuck0", dk, bn, s0, 7, 4'b1111, 1'b0);
        repeat (5) @(negedge clk);
        chk("stuck0_err_hold", err_a, 7);

        mode_a = 2'd2;
        run(1'b0, -1, dk, bn, s0);
        chk_run_a("stuck1", dk, bn, s0, 9, 4'b1111, 1'b0);

        mode_a = 2'd3;
        run(1'b0, -1, dk, bn, s0);
        chk_run_a("nor_as_or", dk, bn, s0, 4, 4'b0100, 1'b0);

        // Abort at cycle 20 of a stuck-at-0 run: vectors 0..4 checked, one AND miss.
        mode_a = 2'd0;
        run(1'b0, -1, dk, bn, s0);
        mode_a = 2'd1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (20) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_pass", pass_a, 0);
        chk("abort_inputs", {in1_a, in2_a}, 0);
        chk("abort_err_hold", err_a, 1);
        chk("abort_mask_hold", mask_a, 4'b0001);

        mode_a = 2'd0;
        run(1'b0, 10, dk, bn, s0);
        chk_run_a("after_abort", dk, bn, s0, 0, 4'b0000, 1'b1);

        @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
        chk("start_abort_idle", busy_a, 0);

        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", {gate_sel_a, in1_a, in2_a, busy_a, done_a, pass_a, err_a, mask_a}, 0);
        @(negedge clk); rst_n = 1'b1;
        run(1'b0, -1, dk, bn, s0);
        chk_run_a("after_reset", dk, bn, s0, 0, 4'b0000, 1'b1);

        mode_b = 2'd2;
        run(1'b1, -1, dk, bn, s0);
        chk("sat_done_cycle", dk, 49);
        chk("sat_busy_cycles", bn, 48);
        chk("sat_err", err_b, 3);
        chk("sat_mask", mask_b, 4'b1111);
        chk("sat_pass", pass_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
